cpu_ir_sequencer: RTL and testbench
===================================

# cpu_ir_sequencer

Instruction fetch and sequencing unit that feeds the per-opcode control decoders. It fetches instruction words from instruction memory into the instruction register (IR) and owns the program counter (PC) and the one-bit micro-step register (State). It consumes the decoder's PS / IR_L / NS outputs to advance PC, State and the fetch/execute cycle. It sits between instruction memory and the decoder bank, and gates datapath writes through exec_en.

## Interface

Parameters:
- PC_W, 16, PC and memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  instruction read request; high only in FETCH.
- mem_addr  out  PC_W  read address; always equals PC.
- mem_data  in  16  instruction word returned by memory.
- mem_valid  in  1  mem_data is valid this cycle; sampled only in FETCH.
- IR  out  16  current instruction to the decoders.
- State  out  1  current micro-step to the decoders.
- PS  in  2  PC select from the decoder: 00 hold, 01 PC+1, 10 PC + sign-extended IR[7:0], 11 load br_target.
- IR_L  in  1  from the decoder: 1 ends the instruction and fetches the next one.
- NS  in  1  next micro-step value from the decoder.
- br_target  in  PC_W  absolute jump target used when PS=11.
- stall  in  1  freezes EXEC for the current cycle.
- exec_en  out  1  high when the decoder outputs are being committed this cycle; the datapath qualifies WR and MW with it.
- inst_cnt  out  16  count of retired instructions.

## Operation

- FSM states are RST, FETCH and EXEC; the state is held in a register and all outputs are registered except mem_req, mem_addr and exec_en.
- Reset values: FSM=RST, PC=RESET_PC, IR=16'h0000, State=0, inst_cnt=0, mem_req=0, exec_en=0.
- RST: always moves to FETCH on the next edge and nothing else changes; this guarantees one idle cycle after reset release.
- FETCH behaviour:
  - mem_req=1 and mem_addr=PC.
  - If mem_valid=1: IR<=mem_data, State<=0, FSM->EXEC.
  - If mem_valid=0: the FSM stays in FETCH and all registers hold.
- EXEC with stall=1: exec_en=0 and all registers hold.
- EXEC with stall=0: exec_en=1, and on the edge:
  - PC is updated per PS.
  - State<=NS.
  - If IR_L=1: FSM->FETCH and inst_cnt increments.
  - If IR_L=0: FSM stays in EXEC with IR held, giving a multi-cycle instruction whose State follows NS.
- PC arithmetic:
  - All PC arithmetic is modulo 2^PC_W: PC=FFFF with PS=01 gives 0000.
  - PS=10 adds {{(PC_W-8){IR[7]}},IR[7:0]} to the current PC, not to PC+1.
- IR_L=1 with PS=00 re-fetches the same address; this is legal.
- mem_valid outside FETCH is ignored; IR never changes outside FETCH.
- inst_cnt wraps from FFFF to 0000.
- An asserted reset_n edge mid-fetch or mid-execute forces the reset values immediately, independent of clk. Any pending memory response is then discarded, because RST does not sample mem_valid.

## Timing

- Zero-wait memory: mem_valid can be high in the first FETCH cycle. A single-step instruction then takes 2 cycles (FETCH, EXEC).
- Each memory wait cycle adds exactly 1 cycle in FETCH.
- Each stall cycle adds exactly 1 cycle in EXEC.
- A multi-step instruction with IR_L=0 for k EXEC cycles takes 2+k cycles.
- First mem_req after reset release is on the second rising edge: the RST cycle comes first, then FETCH.
- IR and State are valid from the first EXEC cycle and stable for all of EXEC. The decoder outputs are therefore combinational from registered values only.
- exec_en is combinational: (FSM==EXEC) & ~stall.

## Test plan

- Reset then load-immediate stream:
  - Stimulus: RESET_PC=0; memory returns word 0x5A03 at address 0 with zero wait; decoder ties PS=01, IR_L=1, NS=0.
  - Required: mem_addr is 0,1,2,… on alternating FETCH cycles; IR=5A03 in the first EXEC; inst_cnt=3 after 6 cycles in FETCH/EXEC.
- Memory wait:
  - Stimulus: mem_valid delayed 3 cycles at PC=4.
  - Required: mem_req stays high for 4 cycles with mem_addr=4; PC, IR and inst_cnt hold; EXEC is entered in the cycle after mem_valid.
- Branches:
  - Stimulus: at PC=0x0010, IR[7:0]=0xFC with PS=10.
  - Required: next PC=0x000C. Then PS=11 with br_target=0x1234 gives PC=0x1234. Then PC=0xFFFF with PS=01 gives PC=0x0000.
- Multi-step instruction:
  - Stimulus: EXEC with IR_L=0, NS=1, then IR_L=1, NS=0.
  - Required: two EXEC cycles, State sequence 0→1→0, IR unchanged, one FETCH afterwards, inst_cnt +1 only.
- Stall:
  - Stimulus: stall=1 for 2 cycles in EXEC with PS=01, IR_L=1.
  - Required: exec_en=0 and PC/State/FSM hold for 2 cycles; the commit happens on the third cycle.
- Async reset mid-fetch:
  - Stimulus: reset_n low while in FETCH at PC=7 with mem_valid arriving in the same cycle.
  - Required: PC=RESET_PC, IR=0, mem_req=0 immediately; the memory word is discarded; fetch restarts at RESET_PC after one RST cycle.

Source files
------------

// File: rtl/cpu_ir_sequencer_if.sv
// Instruction memory read bus between the fetch sequencer (master) and memory (slave).
interface cpu_ir_sequencer_if #(
    parameter int unsigned PC_W = 16
);
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_data;
    logic            mem_valid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_data,
        output mem_valid
    );
endinterface

// File: rtl/cpu_ir_sequencer.sv
// Fetch/execute sequencer: owns PC, IR and the micro-step bit, and advances them
// from the decoder's PS / IR_L / NS outputs.
module cpu_ir_sequencer #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_ir_sequencer_if.master    mem,
    output logic [15:0]           IR,
    output logic                  State,
    input  logic [1:0]            PS,
    input  logic                  IR_L,
    input  logic                  NS,
    input  logic [PC_W-1:0]       br_target,
    input  logic                  stall,
    output logic                  exec_en,
    output logic [15:0]           inst_cnt
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_EXEC
    } fsm_e;

    fsm_e            fsm_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] rel_off;
    logic [15:0]     ir_q;
    logic            step_q;
    logic [15:0]     cnt_q;

    // Relative branches are taken from the current PC, not PC+1.
    assign rel_off = PC_W'($signed(ir_q[7:0]));

    always_comb begin
        pc_d = pc_q;
        unique case (PS)
            2'b00: pc_d = pc_q;
            2'b01: pc_d = pc_q + PC_W'(1);
            2'b10: pc_d = pc_q + rel_off;
            2'b11: pc_d = br_target;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= ST_RST;
            pc_q   <= RESET_PC;
            ir_q   <= '0;
            step_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            unique case (fsm_q)
                ST_RST: begin
                    fsm_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem.mem_valid) begin
                        ir_q   <= mem.mem_data;
                        step_q <= 1'b0;
                        fsm_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_q   <= pc_d;
                        step_q <= NS;
                        if (IR_L) begin
                            fsm_q <= ST_FETCH;
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    fsm_q <= ST_RST;
                end
            endcase
        end
    end

    assign mem.mem_req  = (fsm_q == ST_FETCH);
    assign mem.mem_addr = pc_q;
    assign exec_en      = (fsm_q == ST_EXEC) & ~stall;
    assign IR           = ir_q;
    assign State        = step_q;
    assign inst_cnt     = cnt_q;

endmodule

// File: tb/tb_cpu_ir_sequencer.sv
// Directed and random checks of cpu_ir_sequencer against a cycle-level reference model.
module tb_cpu_ir_sequencer;

    logic        clk;
    logic        reset_n;
    logic [15:0] IR;
    logic        State;
    logic [1:0]  PS;
    logic        IR_L;
    logic        NS;
    logic [15:0] br_target;
    logic        stall;
    logic        exec_en;
    logic [15:0] inst_cnt;

    int n_cmp;
    int n_err;

    // Reference model: phase 0 = idle after reset, 1 = fetching, 2 = executing
    int m_ph;
    int m_pc;
    int m_ir;
    int m_st;
    int m_cnt;

    cpu_ir_sequencer_if #(.PC_W(16)) mif ();

    cpu_ir_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem       (mif),
        .IR        (IR),
        .State     (State),
        .PS        (PS),
        .IR_L      (IR_L),
        .NS        (NS),
        .br_target (br_target),
        .stall     (stall),
        .exec_en   (exec_en),
        .inst_cnt  (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph  = 0;
        m_pc  = 0;
        m_ir  = 0;
        m_st  = 0;
        m_cnt = 0;
    endtask

    function automatic logic [15:0] memfn(input int a);
        return 16'((a * 40503) ^ 16'hA5C3);
    endfunction

    // One clock cycle: drive, check visible outputs, clock, then advance the model.
    task automatic cyc(input logic v, input logic [15:0] d, input logic [1:0] ps,
                       input logic irl, input logic ns, input logic [15:0] br,
                       input logic stl);
        int off;
        mif.mem_valid = v;
        mif.mem_data  = d;
        PS            = ps;
        IR_L          = irl;
        NS            = ns;
        br_target     = br;
        stall         = stl;
        #1;
        check("mem_req",  32'(mif.mem_req),  32'(m_ph == 1));
        check("mem_addr", 32'(mif.mem_addr), 32'(m_pc));
        check("exec_en",  32'(exec_en),      32'(m_ph == 2 && !stl));
        check("IR",       32'(IR),           32'(m_ir));
        check("State",    32'(State),        32'(m_st));
        check("inst_cnt", 32'(inst_cnt),     32'(m_cnt));
        @(posedge clk);
        if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            if (v) begin
                m_ir = int'(d);
                m_st = 0;
                m_ph = 2;
            end
        end else if (!stl) begin
            off = (m_ir % 256 >= 128) ? (m_ir % 256) - 256 : (m_ir % 256);
            case (ps)
                2'b01: m_pc = (m_pc + 1) % 65536;
                2'b10: m_pc = (m_pc + off + 65536) % 65536;
                2'b11: m_pc = int'(br);
                default: ;
            endcase
            m_st = int'(ns);
            if (irl) begin
                m_cnt = (m_cnt + 1) % 65536;
                m_ph  = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        mif.mem_valid = 1'b0;
        mif.mem_data  = '0;
        PS            = 2'b00;
        IR_L          = 1'b0;
        NS            = 1'b0;
        br_target     = '0;
        stall         = 1'b0;
        model_reset();

        // Reset values
        @(negedge clk);
        check("rst_mem_req",  32'(mif.mem_req), 32'h0);
        check("rst_mem_addr", 32'(mif.mem_addr), 32'h0);
        check("rst_IR",       32'(IR), 32'h0);
        check("rst_State",    32'(State), 32'h0);
        check("rst_inst_cnt", 32'(inst_cnt), 32'h0);
        check("rst_exec_en",  32'(exec_en), 32'h0);
        reset_n = 1'b1;

        // Idle RST cycle, then load-immediate stream
        cyc(1'b1, 16'h5A03, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 16'h5A03, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("li_first_IR", 32'(IR), 32'h5A03);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h5A03, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("li_inst_cnt", 32'(inst_cnt), 32'd3);
        check("li_pc", 32'(mif.mem_addr), 32'd3);

        // Memory wait at PC=4
        cyc(1'b1, 16'h1111, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 16'h1111, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'hDEAD, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
            check("wait_addr", 32'(mif.mem_addr), 32'd4);
            check("wait_req", 32'(mif.mem_req), 32'd1);
        end
        cyc(1'b1, 16'h2222, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("wait_IR", 32'(IR), 32'h2222);

        // Branches
        cyc(1'b0, 16'h0, 2'b11, 1'b1, 1'b0, 16'h0010, 1'b0);
        check("br_abs10", 32'(mif.mem_addr), 32'h0010);
        cyc(1'b1, 16'h12FC, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 2'b10, 1'b1, 1'b0, 16'h0, 1'b0);
        check("br_rel", 32'(mif.mem_addr), 32'h000C);
        cyc(1'b1, 16'h4400, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 2'b11, 1'b1, 1'b0, 16'h1234, 1'b0);
        check("br_abs", 32'(mif.mem_addr), 32'h1234);
        cyc(1'b1, 16'h4400, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 2'b11, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        cyc(1'b1, 16'h4400, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("pc_wrap", 32'(mif.mem_addr), 32'h0000);
        check("br_inst_cnt", 32'(inst_cnt), 32'd9);

        // Multi-step instruction
        cyc(1'b1, 16'h7777, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 16'h9999, 2'b00, 1'b0, 1'b1, 16'h0, 1'b0);
        check("ms_state1", 32'(State), 32'd1);
        check("ms_IR", 32'(IR), 32'h7777);
        check("ms_in_exec", 32'(mif.mem_req), 32'd0);
        cyc(1'b1, 16'h9999, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("ms_state0", 32'(State), 32'd0);
        check("ms_inst_cnt", 32'(inst_cnt), 32'd10);
        check("ms_fetch", 32'(mif.mem_req), 32'd1);

        // Stall
        cyc(1'b1, 16'h3333, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 16'h0, 2'b01, 1'b1, 1'b0, 16'h0, 1'b1);
            check("stall_pc", 32'(mif.mem_addr), 32'd1);
            check("stall_cnt", 32'(inst_cnt), 32'd10);
        end
        cyc(1'b0, 16'h0, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("stall_commit_pc", 32'(mif.mem_addr), 32'd2);
        check("stall_commit_cnt", 32'(inst_cnt), 32'd11);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, memfn(m_pc), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 3) == 0);
        end

        // Steer to FETCH at PC=7 (bounded)
        for (int i = 0; i < 10 && !(m_ph == 1 && m_pc == 7); i++) begin
            cyc(1'b1, 16'h5555, 2'b11, 1'b1, 1'b0, 16'h0007, 1'b0);
        end
        check("steer_pc7", 32'(mif.mem_addr), 32'd7);

        // Async reset mid-fetch with a memory response in the same cycle
        mif.mem_valid = 1'b1;
        mif.mem_data  = 16'hBEEF;
        #1;
        check("pre_rst_req", 32'(mif.mem_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_mem_req",  32'(mif.mem_req), 32'd0);
        check("arst_mem_addr", 32'(mif.mem_addr), 32'd0);
        check("arst_IR",       32'(IR), 32'd0);
        check("arst_State",    32'(State), 32'd0);
        check("arst_inst_cnt", 32'(inst_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 16'hBEEF, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("restart_req", 32'(mif.mem_req), 32'd1);
        check("restart_addr", 32'(mif.mem_addr), 32'd0);
        cyc(1'b1, 16'h0ABC, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);
        check("restart_IR", 32'(IR), 32'h0ABC);
        cyc(1'b1, 16'h0ABC, 2'b01, 1'b1, 1'b0, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
